ddr_read_arbiter: RTL and testbench
===================================

Name: ddr_read_arbiter

Overview:
- N-channel DDR read-port arbiter; parametrised successor of the fixed 3-way, externally switched DDR mux.
- Bias, weight and data fetch controllers each latch a read request. A round-robin arbiter picks one requester, issues it to the single DDR read interface, and routes the returned FIFO stream to the granted channel.
- Releases the grant after the last word is delivered. No topcontrol `switch` input is needed.

Parameters:
- N_CH, 3: number of client channels (2..8).
- DDR_ADDR_LEN, 32: DDR byte-address width.
- DDR_DATA_LEN, 64: DDR FIFO word width in bits; must be a power of two and at least 8.
- SINGLE_LEN, 24: request-length field width, in bytes.
- MAX_BURST_WORDS, 16: chunk size in words; used only with DDR_ARB_SPLIT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cli_st_addr  in  N_CH*DDR_ADDR_LEN  per-channel start byte address; channel c occupies slice [c*DDR_ADDR_LEN +: DDR_ADDR_LEN].
- cli_len  in  N_CH*SINGLE_LEN  per-channel length in bytes.
- cli_conf  in  N_CH  one-cycle request strobe.
- cli_busy  out  N_CH  request latched and not yet complete.
- cli_fifo_empty  out  N_CH  per-channel FIFO empty.
- cli_fifo_req  in  N_CH  per-channel FIFO pop.
- cli_fifo_data  out  DDR_DATA_LEN  shared data bus; valid for the granted channel only.
- ddr_st_addr_out  out  DDR_ADDR_LEN  issued start address.
- ddr_len  out  SINGLE_LEN  issued length in bytes.
- ddr_conf  out  1  one-cycle issue strobe.
- ddr_fifo_empty  in  1  DDR read FIFO empty.
- ddr_fifo_req  out  1  DDR read FIFO pop.
- ddr_fifo_data  in  DDR_DATA_LEN  DDR read FIFO data.
- grant  out  N_CH  one-hot owner while in ISSUE or STREAM; 0 otherwise.
- idle  out  1  state IDLE and no channel busy.

Behaviour:
- Reset values: cli_busy=0, cli_fifo_empty=all 1, ddr_conf=0, ddr_fifo_req=0, ddr_st_addr_out=0, ddr_len=0, grant=0, idle=1. last_grant resets to N_CH-1, so channel 0 wins first.
- Capture: cli_conf[c] while cli_busy[c]=0 latches addr and len for channel c and sets cli_busy[c] on the next edge.
  - cli_conf[c] while cli_busy[c]=1 is ignored.
  - Simultaneous conf on several channels latches all of them.
- Word count: BPW = DDR_DATA_LEN/8; words = ceil(len/BPW). Example: len 20, BPW 8 gives 3 words.
- FSM states: IDLE, ISSUE, STREAM.
- IDLE:
  - If any cli_busy is set, select the first busy channel searching upward from last_grant+1, modulo N_CH.
  - Update last_grant and go to ISSUE.
  - Arbitration costs 1 cycle.
- ISSUE (1 cycle):
  - Drive ddr_conf=1 with the latched addr and len, load the word counter, go to STREAM.
  - If len=0: no ddr_conf, clear cli_busy[g], return to IDLE.
- STREAM:
  - cli_fifo_empty[g] = ddr_fifo_empty; all other channels see 1.
  - ddr_fifo_req = cli_fifo_req[g] & ~ddr_fifo_empty.
  - cli_fifo_data = ddr_fifo_data, combinational with zero added latency.
  - Pops on non-granted channels are ignored.
  - Each pop decrements the counter. The pop that takes it 1→0 clears cli_busy[g] and returns to IDLE on the same edge.
- Requests latched during STREAM wait; there is no pre-emption.
- Reset mid-operation returns every register to its reset value. The DDR side is reset together, so no drain is performed.

Optional Feature:
- Macro: DDR_ARB_SPLIT_EN.
- Defined:
  - ISSUE issues chunk = min(remaining words, MAX_BURST_WORDS); ddr_len = chunk*BPW, or the remaining bytes for the final chunk.
  - At chunk end, if words remain: advance the latched addr by chunk*BPW, reduce the latched len, keep cli_busy, return to IDLE and re-arbitrate.
  - Long transfers therefore interleave with other channels.
- Undefined: the whole request is issued in one ddr_conf.

Decomposition:
- Package ddr_arb_pkg holds:
  - state encoding (IDLE, ISSUE, STREAM);
  - BPW and its log2 constant;
  - a clog2 function;
  - a words-from-bytes function.
- One sub-module, rr_arbiter (inputs: request vector, last_grant; output: one-hot pick), combinational, parametrised by N_CH.

Test Plan:
- ch0 conf, addr 0x1000, len 64, FIFO always non-empty, cli_fifo_req[0]=1 → one ddr_conf with 0x1000/64; exactly 8 pops to ch0; cli_busy[0] falls after the 8th pop; idle=1.
- ch0 and ch1 conf in the same cycle → ch0 served fully, then ch1. Afterwards ch1 and ch2 conf together → ch2 served first (searching from last_grant+1 = 2).
- len=0 on ch2 → no ddr_conf; cli_busy[2] clears within 2 cycles of the grant. len=20 → 3 pops.
- ddr_fifo_empty toggled randomly during STREAM → ddr_fifo_req never asserted while empty; the word count is still exact. Pops on a non-granted channel have no effect.
- DDR_ARB_SPLIT_EN, MAX_BURST_WORDS=16: ch0 len 256 plus ch1 len 64 pending → ddr_conf sequence ch0 (128 B), ch1 (64 B), ch0 addr+128 (128 B).
- rst asserted mid-STREAM → next cycle: every output at its reset value, cli_busy=0, and a new ch0 conf is served normally.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR read-port arbiter.
// Holds the FSM encoding, default bytes-per-word constants and sizing helpers.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_DDR_DATA_LEN = 64;
  localparam int BPW              = DEF_DDR_DATA_LEN / 8;
  localparam int BPW_LOG2         = clog2(BPW);

  // Bytes-per-word is a power of two, so ceil(bytes/BPW) reduces to add-and-shift.
  function automatic logic [31:0] words_from_bytes(input logic [31:0] bytes, input int bpw_log2);
    return (bytes + ((32'd1 << bpw_log2) - 32'd1)) >> bpw_log2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last_grant+1.
module rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int LGW  = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [LGW-1:0]  last_grant,
  output logic [N_CH-1:0] pick
);

  // Walk the search order backwards so the nearest requester is written last and wins.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % N_CH;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_read_arbiter.sv
// N-channel DDR read-port arbiter: latches client requests, issues one at a time, routes the FIFO stream.
// Define DDR_ARB_SPLIT_EN to break long transfers into MAX_BURST_WORDS chunks that re-arbitrate.
module ddr_read_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_CH            = 3,
  parameter int DDR_ADDR_LEN    = 32,
  parameter int DDR_DATA_LEN    = 64,
  parameter int SINGLE_LEN      = 24,
  parameter int MAX_BURST_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH*DDR_ADDR_LEN-1:0] cli_st_addr,
  input  logic [N_CH*SINGLE_LEN-1:0]   cli_len,
  input  logic [N_CH-1:0]              cli_conf,
  output logic [N_CH-1:0]              cli_busy,
  output logic [N_CH-1:0]              cli_fifo_empty,
  input  logic [N_CH-1:0]              cli_fifo_req,
  output logic [DDR_DATA_LEN-1:0]      cli_fifo_data,
  output logic [DDR_ADDR_LEN-1:0]      ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]        ddr_len,
  output logic                         ddr_conf,
  input  logic                         ddr_fifo_empty,
  output logic                         ddr_fifo_req,
  input  logic [DDR_DATA_LEN-1:0]      ddr_fifo_data,
  output logic [N_CH-1:0]              grant,
  output logic                         idle
);

  localparam int LGW        = clog2(N_CH);
  localparam int L_BPW_LOG2 = clog2(DDR_DATA_LEN / 8);

  if (N_CH < 2 || N_CH > 8 || DDR_DATA_LEN < 8 || (DDR_DATA_LEN & (DDR_DATA_LEN - 1)) != 0
      || MAX_BURST_WORDS < 1) begin : g_bad_cfg
    $error("ddr_read_arbiter: unsupported parameter set");
  end

`ifdef DDR_ARB_SPLIT_EN
  localparam logic [SINGLE_LEN-1:0] CHUNK_WORDS = SINGLE_LEN'(MAX_BURST_WORDS);
  localparam logic [SINGLE_LEN-1:0] CHUNK_BYTES = SINGLE_LEN'(MAX_BURST_WORDS * (DDR_DATA_LEN / 8));
`endif

  logic [N_CH-1:0][DDR_ADDR_LEN-1:0] addr_q, addr_d, addr_in;
  logic [N_CH-1:0][SINGLE_LEN-1:0]   len_q, len_d, len_in;
  logic [N_CH-1:0]                   busy_q, busy_d, pick;
  arb_state_e                        state_q, state_d;
  logic [LGW-1:0]                    last_grant_q, last_grant_d, gnt_q, gnt_d, pick_idx;
  logic [SINGLE_LEN-1:0]             cnt_q, cnt_d, words_g;

  assign addr_in        = cli_st_addr;
  assign len_in         = cli_len;
  assign cli_busy       = busy_q;
  assign cli_fifo_data  = ddr_fifo_data;
  assign idle           = (state_q == ST_IDLE) && (busy_q == '0);
  assign words_g        = SINGLE_LEN'(words_from_bytes(32'(len_q[gnt_q]), L_BPW_LOG2));

  rr_arbiter #(.N_CH(N_CH), .LGW(LGW)) u_rr (
    .req        (busy_q),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (pick[c]) pick_idx = LGW'(c);
    end
  end

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    addr_d          = addr_q;
    len_d           = len_q;
    last_grant_d    = last_grant_q;
    gnt_d           = gnt_q;
    cnt_d           = cnt_q;
    ddr_conf        = 1'b0;
    ddr_st_addr_out = '0;
    ddr_len         = '0;
    ddr_fifo_req    = 1'b0;
    cli_fifo_empty  = '1;
    grant           = '0;

    // A busy channel owns its latched addr/len; a strobe then is dropped.
    for (int c = 0; c < N_CH; c++) begin
      if (cli_conf[c] && !busy_q[c]) begin
        busy_d[c] = 1'b1;
        addr_d[c] = addr_in[c];
        len_d[c]  = len_in[c];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (busy_q != '0) begin
          gnt_d        = pick_idx;
          last_grant_d = pick_idx;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        grant[gnt_q] = 1'b1;
        if (len_q[gnt_q] == '0) begin
          busy_d[gnt_q] = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          ddr_conf        = 1'b1;
          ddr_st_addr_out = addr_q[gnt_q];
          state_d         = ST_STREAM;
`ifdef DDR_ARB_SPLIT_EN
          // Latched addr/len are advanced now; the bus copy above uses the pre-edge values.
          if (words_g > CHUNK_WORDS) begin
            ddr_len       = CHUNK_BYTES;
            cnt_d         = CHUNK_WORDS;
            addr_d[gnt_q] = addr_q[gnt_q] + DDR_ADDR_LEN'(CHUNK_BYTES);
            len_d[gnt_q]  = len_q[gnt_q] - CHUNK_BYTES;
          end else begin
            ddr_len      = len_q[gnt_q];
            cnt_d        = words_g;
            len_d[gnt_q] = '0;
          end
`else
          ddr_len = len_q[gnt_q];
          cnt_d   = words_g;
`endif
        end
      end
      ST_STREAM: begin
        grant[gnt_q]          = 1'b1;
        cli_fifo_empty[gnt_q] = ddr_fifo_empty;
        ddr_fifo_req          = cli_fifo_req[gnt_q] & ~ddr_fifo_empty;
        if (ddr_fifo_req) begin
          cnt_d = cnt_q - SINGLE_LEN'(1);
          if (cnt_q == SINGLE_LEN'(1)) begin
            state_d = ST_IDLE;
`ifdef DDR_ARB_SPLIT_EN
            if (len_q[gnt_q] == '0) busy_d[gnt_q] = 1'b0;
`else
            busy_d[gnt_q] = 1'b0;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      last_grant_q <= LGW'(N_CH - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter (3 channels, 32-bit addr, 64-bit data, 24-bit len).
module tb_ddr_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] cli_st_addr;
  logic [71:0] cli_len;
  logic [2:0]  cli_conf;
  logic [2:0]  cli_busy;
  logic [2:0]  cli_fifo_empty;
  logic [2:0]  cli_fifo_req;
  logic [63:0] cli_fifo_data;
  logic [31:0] ddr_st_addr_out;
  logic [23:0] ddr_len;
  logic        ddr_conf;
  logic        ddr_fifo_empty;
  logic        ddr_fifo_req;
  logic [63:0] ddr_fifo_data;
  logic [2:0]  grant;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] conf_addr_q[$];
  logic [23:0] conf_len_q[$];
  logic [2:0]  conf_gnt_q[$];
  int          pops[3];
  int          viol;
  int          stray;

  ddr_read_arbiter dut (
    .clk(clk), .rst(rst), .cli_st_addr(cli_st_addr), .cli_len(cli_len), .cli_conf(cli_conf),
    .cli_busy(cli_busy), .cli_fifo_empty(cli_fifo_empty), .cli_fifo_req(cli_fifo_req),
    .cli_fifo_data(cli_fifo_data), .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len),
    .ddr_conf(ddr_conf), .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_req(ddr_fifo_req),
    .ddr_fifo_data(ddr_fifo_data), .grant(grant), .idle(idle)
  );

  // clock / reset
  always #5 clk = ~clk;

  // issue and pop monitor, sampled at the active edge on values driven 1 time unit after the previous edge
  always @(posedge clk) begin
    if (!rst) begin
      if (ddr_conf) begin
        conf_addr_q.push_back(ddr_st_addr_out);
        conf_len_q.push_back(ddr_len);
        conf_gnt_q.push_back(grant);
      end
      if (ddr_fifo_req) begin
        if (ddr_fifo_empty) viol++;
        if (grant == 3'b000) stray++;
        for (int c = 0; c < 3; c++) if (grant[c]) pops[c]++;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    conf_addr_q.delete();
    conf_len_q.delete();
    conf_gnt_q.delete();
    for (int c = 0; c < 3; c++) pops[c] = 0;
    viol  = 0;
    stray = 0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] a, input logic [23:0] l);
    cli_st_addr[ch*32 +: 32] = a;
    cli_len[ch*24 +: 24]     = l;
  endtask

  task automatic pulse(input logic [2:0] mask);
    cli_conf = mask;
    step(1);
    cli_conf = 3'b000;
  endtask

  task automatic wait_idle(input int budget, input bit rnd, output int cycles);
    cycles = 0;
    while (idle !== 1'b1 && cycles < budget) begin
      if (rnd) ddr_fifo_empty = 1'($urandom_range(0, 1));
      step(1);
      cycles++;
    end
    ddr_fifo_empty = 1'b0;
    n_cmp++;
    if (idle !== 1'b1) begin
      n_err++;
      $display("FAIL idle_timeout: idle=%0b after %0d cycles, required 1", idle, cycles);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    n_cmp++;
    if (cli_busy !== 3'b000 || cli_fifo_empty !== 3'b111 || ddr_conf !== 1'b0 ||
        ddr_fifo_req !== 1'b0 || ddr_st_addr_out !== 32'h0 || ddr_len !== 24'h0 ||
        grant !== 3'b000 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL %s: busy=%b empty=%b conf=%b req=%b addr=%h len=%0d grant=%b idle=%b, required 000 111 0 0 0 0 000 1",
               tag, cli_busy, cli_fifo_empty, ddr_conf, ddr_fifo_req, ddr_st_addr_out, ddr_len, grant, idle);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    step(2);
    check_outputs_reset("reset_values");
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_same_cycle();
    int cyc;
    clear_logs();
    cli_fifo_req = 3'b111;
    set_ch(0, 32'h2000, 24'd16);
    set_ch(1, 32'h3000, 24'd24);
    pulse(3'b011);
    n_cmp++;
    if (cli_busy !== 3'b011) begin
      n_err++;
      $display("FAIL both_latched: busy=%b required 011", cli_busy);
    end
    wait_idle(60, 1'b0, cyc);
    n_cmp++;
    if (conf_gnt_q.size() != 2 || conf_gnt_q[0] !== 3'b001 || conf_gnt_q[1] !== 3'b010) begin
      n_err++;
      $display("FAIL order_ch0_ch1: n=%0d first=%b second=%b required 2 001 010",
               conf_gnt_q.size(), conf_gnt_q[0], conf_gnt_q[1]);
    end
    n_cmp++;
    if (conf_addr_q[0] !== 32'h2000 || conf_len_q[0] !== 24'd16 ||
        conf_addr_q[1] !== 32'h3000 || conf_len_q[1] !== 24'd24) begin
      n_err++;
      $display("FAIL issue_fields_01: %h/%0d %h/%0d required 2000/16 3000/24",
               conf_addr_q[0], conf_len_q[0], conf_addr_q[1], conf_len_q[1]);
    end
    n_cmp++;
    if (pops[0] != 2 || pops[1] != 3 || stray != 0) begin
      n_err++;
      $display("FAIL pops_01: ch0=%0d ch1=%0d stray=%0d required 2 3 0", pops[0], pops[1], stray);
    end

    clear_logs();
    set_ch(1, 32'h4000, 24'd8);
    set_ch(2, 32'h5000, 24'd32);
    pulse(3'b110);
    wait_idle(60, 1'b0, cyc);
    n_cmp++;
    if (conf_gnt_q.size() != 2 || conf_gnt_q[0] !== 3'b100 || conf_gnt_q[1] !== 3'b010) begin
      n_err++;
      $display("FAIL order_ch2_ch1: n=%0d first=%b second=%b required 2 100 010",
               conf_gnt_q.size(), conf_gnt_q[0], conf_gnt_q[1]);
    end
    n_cmp++;
    if (pops[2] != 4 || pops[1] != 1 || pops[0] != 0) begin
      n_err++;
      $display("FAIL pops_21: ch0=%0d ch1=%0d ch2=%0d required 0 1 4", pops[0], pops[1], pops[2]);
    end
  endtask

  task automatic test_single();
    int cyc;
    clear_logs();
    cli_fifo_req = 3'b001;
    set_ch(0, 32'h1000, 24'd64);
    pulse(3'b001);
    step(2);
    n_cmp++;
    if (grant !== 3'b001 || cli_fifo_empty !== 3'b110 || cli_fifo_data !== ddr_fifo_data) begin
      n_err++;
      $display("FAIL stream_route: grant=%b empty=%b data=%h required 001 110 %h",
               grant, cli_fifo_empty, cli_fifo_data, ddr_fifo_data);
    end
    wait_idle(40, 1'b0, cyc);
    n_cmp++;
    if (cyc != 8) begin
      n_err++;
      $display("FAIL stream_cycles: %0d cycles required 8", cyc);
    end
    n_cmp++;
    if (conf_addr_q.size() != 1 || conf_addr_q[0] !== 32'h1000 || conf_len_q[0] !== 24'd64) begin
      n_err++;
      $display("FAIL single_issue: n=%0d addr=%h len=%0d required 1 1000 64",
               conf_addr_q.size(), conf_addr_q[0], conf_len_q[0]);
    end
    n_cmp++;
    if (pops[0] != 8 || cli_busy !== 3'b000) begin
      n_err++;
      $display("FAIL single_pops: pops=%0d busy=%b required 8 000", pops[0], cli_busy);
    end
  endtask

  task automatic test_len_zero();
    int cyc;
    clear_logs();
    cli_fifo_req = 3'b100;
    set_ch(2, 32'h6000, 24'd0);
    pulse(3'b100);
    step(1);
    n_cmp++;
    if (grant !== 3'b100 || ddr_conf !== 1'b0) begin
      n_err++;
      $display("FAIL zero_issue: grant=%b conf=%b required 100 0", grant, ddr_conf);
    end
    step(1);
    n_cmp++;
    if (cli_busy !== 3'b000 || idle !== 1'b1 || conf_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_done: busy=%b idle=%b confs=%0d required 000 1 0",
               cli_busy, idle, conf_addr_q.size());
    end

    clear_logs();
    set_ch(2, 32'h6100, 24'd20);
    pulse(3'b100);
    wait_idle(40, 1'b0, cyc);
    n_cmp++;
    if (conf_len_q.size() != 1 || conf_len_q[0] !== 24'd20 || pops[2] != 3) begin
      n_err++;
      $display("FAIL len20: confs=%0d len=%0d pops=%0d required 1 20 3",
               conf_len_q.size(), conf_len_q[0], pops[2]);
    end
  endtask

  task automatic test_random_empty();
    int cyc;
    clear_logs();
    set_ch(0, 32'h7000, 24'd64);
    set_ch(1, 32'h7100, 24'd8);
    cli_fifo_req = 3'b110;
    pulse(3'b001);
    step(6);
    n_cmp++;
    if (pops[0] != 0 || pops[1] != 0 || cli_busy !== 3'b001) begin
      n_err++;
      $display("FAIL foreign_pop: ch0=%0d ch1=%0d busy=%b required 0 0 001", pops[0], pops[1], cli_busy);
    end
    cli_fifo_req = 3'b111;
    wait_idle(200, 1'b1, cyc);
    n_cmp++;
    if (pops[0] != 8 || viol != 0 || stray != 0) begin
      n_err++;
      $display("FAIL random_empty: pops=%0d pop_while_empty=%0d stray=%0d required 8 0 0",
               pops[0], viol, stray);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_logs();
    cli_fifo_req = 3'b001;
    set_ch(0, 32'h7800, 24'd64);
    pulse(3'b001);
    step(4);
    rst = 1'b1;
    step(1);
    check_outputs_reset("reset_mid_stream");
    rst = 1'b0;
    clear_logs();
    cli_fifo_req = 3'b111;
    set_ch(0, 32'hA000, 24'd8);
    set_ch(2, 32'hB000, 24'd8);
    pulse(3'b101);
    wait_idle(40, 1'b0, cyc);
    n_cmp++;
    if (conf_gnt_q.size() != 2 || conf_gnt_q[0] !== 3'b001 || conf_addr_q[0] !== 32'hA000 ||
        conf_gnt_q[1] !== 3'b100) begin
      n_err++;
      $display("FAIL after_reset: n=%0d g0=%b a0=%h g1=%b required 2 001 a000 100",
               conf_gnt_q.size(), conf_gnt_q[0], conf_addr_q[0], conf_gnt_q[1]);
    end
    n_cmp++;
    if (pops[0] != 1 || pops[2] != 1) begin
      n_err++;
      $display("FAIL after_reset_pops: ch0=%0d ch2=%0d required 1 1", pops[0], pops[2]);
    end
  endtask

`ifdef DDR_ARB_SPLIT_EN
  task automatic test_split();
    int cyc;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    clear_logs();
    cli_fifo_req = 3'b111;
    set_ch(0, 32'h8000, 24'd256);
    set_ch(1, 32'h9000, 24'd64);
    pulse(3'b011);
    wait_idle(200, 1'b0, cyc);
    n_cmp++;
    if (conf_gnt_q.size() != 3 || conf_gnt_q[0] !== 3'b001 || conf_gnt_q[1] !== 3'b010 ||
        conf_gnt_q[2] !== 3'b001) begin
      n_err++;
      $display("FAIL split_order: n=%0d %b %b %b required 3 001 010 001",
               conf_gnt_q.size(), conf_gnt_q[0], conf_gnt_q[1], conf_gnt_q[2]);
    end
    n_cmp++;
    if (conf_addr_q[0] !== 32'h8000 || conf_len_q[0] !== 24'd128 || conf_addr_q[1] !== 32'h9000 ||
        conf_len_q[1] !== 24'd64 || conf_addr_q[2] !== 32'h8080 || conf_len_q[2] !== 24'd128) begin
      n_err++;
      $display("FAIL split_fields: %h/%0d %h/%0d %h/%0d required 8000/128 9000/64 8080/128",
               conf_addr_q[0], conf_len_q[0], conf_addr_q[1], conf_len_q[1], conf_addr_q[2], conf_len_q[2]);
    end
    n_cmp++;
    if (pops[0] != 32 || pops[1] != 8) begin
      n_err++;
      $display("FAIL split_pops: ch0=%0d ch1=%0d required 32 8", pops[0], pops[1]);
    end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    cli_st_addr    = '0;
    cli_len        = '0;
    cli_conf       = 3'b000;
    cli_fifo_req   = 3'b000;
    ddr_fifo_empty = 1'b0;
    ddr_fifo_data  = 64'hDEAD_BEEF_0123_4567;
    clear_logs();
    @(posedge clk);
    #1;
    test_reset();
    test_same_cycle();
    test_single();
    test_len_zero();
    test_random_empty();
    test_reset_mid();
`ifdef DDR_ARB_SPLIT_EN
    test_split();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
